// File: rtl/cpu_trace_tx_pkg.sv
// Shared constants, FSM encoding and byte-select helper for the CPU trace transmitter.
// One record is six CPU fields; one frame is sync + sequence + 44 record bytes.
package cpu_trace_tx_pkg;

    localparam int REC_W      = 352;
    localparam int SEQ_W      = 8;
    localparam int FRAME_LEN  = 46;
    localparam int DATA_BYTES = FRAME_LEN - 2;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam logic [5:0] LAST_IDX          = 6'(DATA_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_SEQ  = 2'd2,
        ST_DATA = 2'd3
    } tx_state_e;

    // Byte 0 is the least significant byte of counter.
    function automatic logic [7:0] rec_byte(input logic [REC_W-1:0] rec,
                                            input logic [5:0]       idx);
        return rec[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO for trace entries; the head entry is presented combinationally.
// Latency: a push is visible at the head after one edge. Full is judged before a same-cycle pop.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
            else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/cpu_trace_tx.sv
// Captures CPU state records into a FIFO and serialises each as a 46-byte framed byte stream.
// Latency: capture at edge N into an idle, empty block shows the sync byte after edge N+1.
// Backpressure: tx_valid/tx_data hold while tx_ready is low; captures into a full FIFO are dropped and counted.
module cpu_trace_tx
    import cpu_trace_tx_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        capture_en,
    input  logic [63:0] counter,
    input  logic [31:0] instruction,
    input  logic [63:0] read1,
    input  logic [63:0] read2,
    input  logic [63:0] ALUout,
    input  logic [63:0] memdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        overflow,
    output logic [15:0] drop_count
);

    localparam int FIFO_W = SEQ_W + REC_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    tx_state_e         state_q, state_d;
    logic [5:0]        idx_q, idx_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [SEQ_W-1:0]  seq_q;
    logic              overflow_q;
    logic [15:0]       drop_count_q;

    logic [FIFO_W-1:0] head;
    logic [SEQ_W-1:0]  head_seq;
    logic [REC_W-1:0]  head_rec;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              pop;
    logic              accept;
    logic              drop;
    logic              xfer;

    assign accept = capture_en && !fifo_full && !reset;
    assign drop   = capture_en && fifo_full && !reset;
    assign xfer   = tx_valid_q && tx_ready;

    trace_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .push_i  (capture_en),
        .pop_i   (pop),
        .din_i   ({seq_q, memdata, ALUout, read2, read1, instruction, counter}),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_seq = head[FIFO_W-1 -: SEQ_W];
    assign head_rec = head[REC_W-1:0];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d    = ST_HDR;
                    tx_valid_d = 1'b1;
                    tx_data_d  = SYNC_BYTE;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    state_d   = ST_SEQ;
                    tx_data_d = head_seq;
                end
            end
            ST_SEQ: begin
                if (xfer) begin
                    state_d   = ST_DATA;
                    idx_d     = 6'd0;
                    tx_data_d = rec_byte(head_rec, 6'd0);
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        pop   = 1'b1;
                        idx_d = 6'd0;
                        // A capture landing on the popping edge keeps the FIFO non-empty.
                        if (fifo_count > CNT_W'(1) || accept) begin
                            state_d   = ST_HDR;
                            tx_data_d = SYNC_BYTE;
                        end else begin
                            state_d    = ST_IDLE;
                            tx_valid_d = 1'b0;
                            tx_data_d  = 8'h00;
                        end
                    end else begin
                        idx_d     = idx_q + 6'd1;
                        tx_data_d = rec_byte(head_rec, idx_q + 6'd1);
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= 6'd0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            seq_q        <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            if (accept) seq_q <= seq_q + 1'b1;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
            end
        end
    end

    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: doc/cpu_trace_tx.md
CPU_TRACE_TX -- requirements
Module: cpu_trace_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: number of trace records buffered; power of two, 2..16.
REQ-002 Parameter SYNC_BYTE, default 8'hA5: first byte of every frame.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 capture_en  input  1  when high, one record is captured per rising edge.
REQ-006 counter  input  64  CPU program counter.
REQ-007 instruction  input  32  current instruction word.
REQ-008 read1, read2  input  64 each  register-file read ports.
REQ-009 ALUout, memdata  input  64 each  ALU result and data-memory read data.
REQ-010 tx_data  output  8  serialized trace byte.
REQ-011 tx_valid  output  1  tx_data holds a valid byte.
REQ-012 tx_ready  input  1  downstream accepts the byte; a transfer occurs when tx_valid and tx_ready are both high.
REQ-013 overflow  output  1  sticky; set when a record was dropped.
REQ-014 drop_count  output  16  saturating count of dropped records.

Function
REQ-015 A record SHALL be the 352-bit concatenation {memdata, ALUout, read2, read1, instruction, counter}, sampled on the rising edge where capture_en=1.
REQ-016 A capture SHALL push into the FIFO if the FIFO is not full, judged before any same-cycle pop; otherwise the record is dropped.
REQ-017 A dropped record SHALL set overflow and increment drop_count; drop_count holds at 16'hFFFF.
REQ-018 Each accepted record SHALL receive an 8-bit sequence number, starting at 0 and wrapping 255->0; dropped records consume no number.
REQ-019 A frame SHALL be 46 bytes: SYNC_BYTE, seq, then 44 record bytes, little-endian per field, field order counter, instruction, read1, read2, ALUout, memdata.
REQ-020 The serializer FSM SHALL have states IDLE, HDR, SEQ and DATA; the DATA state uses a 6-bit byte index from 0 to 43.
REQ-021 IDLE->HDR when the FIFO is non-empty; HDR->SEQ on transfer; SEQ->DATA (index 0) on transfer; in DATA, index+1 on transfer.
REQ-022 Transfer at index 43 SHALL pop the FIFO in that cycle. Next state is HDR if another record remains after the pop, otherwise IDLE; no idle bubble between back-to-back frames.
REQ-023 tx_valid and tx_data SHALL be registered; while tx_valid=1 and tx_ready=0, both are held stable.
REQ-024 Latency: a record captured into an empty FIFO at edge N with the FSM in IDLE SHALL produce tx_valid=1 with tx_data=SYNC_BYTE after edge N+1.
REQ-025 tx_valid SHALL be 0 only in IDLE; tx_ready is ignored in IDLE.
REQ-026 A simultaneous push and pop on a non-full FIFO SHALL leave the occupancy unchanged and keep both records.
REQ-027 Deasserting capture_en SHALL NOT abort the frame in progress or flush buffered records.

Reset
REQ-028 On reset the block SHALL be in the following state: FSM in IDLE, FIFO empty, seq=0, tx_valid=0, tx_data=8'h00, overflow=0, drop_count=0.
REQ-029 Reset mid-frame SHALL abort the frame immediately; the partial frame is not completed and the buffered records are discarded.
REQ-030 A capture requested in the reset cycle SHALL be ignored.

Structure
REQ-031 The shared package SHALL hold the record width (352), frame length (46), the FSM state encoding and the default SYNC_BYTE.
REQ-032 The FIFO SHALL be a separate sub-module, trace_fifo, with parameterized width and depth and with push, pop, full, empty and occupancy signals.
REQ-033 Byte selection from the FIFO head SHALL be a shift-free multiplexer indexed by the byte index; the record is not copied into a shift register.

Verification
REQ-034 Reset, then one capture with counter=64'h10, instruction=32'h8B020020 and tx_ready=1 -> 46 consecutive bytes: A5, 00, 10, 00 x7, 20, 00, 02, 8B, ...; then tx_valid=0.
REQ-035 tx_ready toggled 1/0 every cycle during a frame -> tx_data is stable while stalled, all 46 bytes arrive in order, and no byte is duplicated.
REQ-036 capture_en held high for 10 cycles with tx_ready=0 at depth 4 -> 4 records stored, 6 dropped, drop_count=6, overflow=1. Then tx_ready=1 -> 4 frames with seq 0,1,2,3, sent back-to-back.
REQ-037 Capture on the same edge that pops the last byte of a frame while full -> the record is dropped and drop_count increments by 1.
REQ-038 Reset asserted at byte 20 of a frame -> tx_valid=0 on the next cycle; the next capture yields a frame with seq=00.
REQ-039 300 accepted records with no drops -> sequence bytes wrap FF->00 and overflow stays 0.
